mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit beside the ALU in the execute stage.
- Consumes register operands srca/srcb and produces the HI/LO pair that mfhi/mflo return to the writeback result mux.
- Replaces the combinational {HI,LO} path inside the ALU.
- Multi-cycle: asserts busy so the control unit stalls the PC while an operation runs.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset on next rising clk).
- start  input  1  launch op with a/b; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- mthi  input  1  write wdata to HI; honoured in IDLE only.
- mtlo  input  1  write wdata to LO; honoured in IDLE only.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in flight; control must stall.
- done  output  1  one-cycle pulse in the first cycle new HI/LO is visible.
- divzero  output  1  sticky flag, set by a divide with b==0; cleared by the next start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; hi=lo=0; busy=done=divzero=0; counter=0.
  - Aborts any operation in flight; no partial result is written.
- States:
  - IDLE -> RUN on start (b!=0 or a multiply op).
  - IDLE -> DZ on a divide start with b==0.
  - RUN -> FIX when counter reaches WIDTH-1.
  - FIX -> IDLE.
  - DZ -> IDLE.
- Start edge (edge 0):
  - Latch op.
  - Signed ops: latch |a|, |b| as unsigned magnitudes and record sign_a and sign_b.
  - Unsigned ops: latch raw values.
  - Set divzero=0 (or 1 for the DZ path); busy=1 from the cycle after edge 0.
- RUN, one bit per edge, 32 edges:
  - Multiply: shift-add on 64-bit {acc, mplier}.
  - Divide: restoring divide, one quotient bit per edge; 33-bit trial subtraction.
- FIX edge (edge 33):
  - Product is negated (two's complement, 64-bit) if sign_a^sign_b.
  - Quotient is negated if sign_a^sign_b; remainder takes the sign of the dividend.
  - hi/lo are written; busy=0 and done=1 in the following cycle.
- Total latency: start edge to done-high cycle = 34 clocks.
- DZ (one edge): lo=all ones; hi=a (raw); divzero=1; done=1 the next cycle. Latency 2 clocks.
- DIV 0x80000000 / 0xFFFFFFFF: falls out of the magnitude arithmetic as lo=0x80000000, hi=0. No special case.
- hi/lo hold their values between operations; outputs are direct register outputs, no combinational path from inputs.
- start while busy: ignored, no queueing. mthi/mtlo while busy: ignored.
- start with mthi/mtlo in the same IDLE cycle: start wins, move dropped.
- mthi and mtlo in the same cycle: both written.
- op and a/b are don't-care after the start edge. The unit uses latched copies; upstream may change operands freely.
- done never asserts without a preceding accepted start.

Decomposition:
- Package mdu_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum: IDLE, RUN, FIX, DZ.
  - constant ITER = 32.
- Sub-module mdu_sign_fix: combinational magnitude/negate helper, instantiated once for operand abs and once for result fix-up.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 clocks done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); DIVU a=100 b=7 -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=0x1234 b=0 -> done after 2 clocks, divzero=1, lo=0xFFFFFFFF, hi=0x00001234; next MULTU start clears divzero.
- Start MULTU 5*6, pulse start (DIVU 9/3) and mthi (wdata=0xAAAA) at cycle 10 -> both ignored; result hi=0, lo=30.
- Start MULT, drive reset=0 for one edge at cycle 15 -> busy=0, hi=lo=0, no done; then mtlo wdata=0x55 in IDLE -> lo=0x55 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DZ
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate of a HI/LO pair. In wide mode the pair
// is negated as one double-width value (signed product); otherwise each half
// is negated independently (operand magnitudes, quotient/remainder).
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_hi,
    input  logic [W-1:0] i_lo,
    input  logic         i_neg_hi,
    input  logic         i_neg_lo,
    input  logic         i_wide,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    logic [2*W-1:0] w_cat;
    logic [2*W-1:0] w_cat_neg;

    assign w_cat     = {i_hi, i_lo};
    assign w_cat_neg = -w_cat;

    // Select pass-through or negated halves.
    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        if (i_wide) begin
            if (i_neg_hi) {o_hi, o_lo} = w_cat_neg;
        end else begin
            if (i_neg_hi) o_hi = -i_hi;
            if (i_neg_lo) o_lo = -i_lo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit. One bit per clock on unsigned
// magnitudes, then a single fix-up edge restores signs and writes HI/LO.
// Multiply keeps {acc, shr} as the 64-bit shift-add pair; divide reuses the
// same registers as {remainder, dividend/quotient} for restoring division.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITER,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             r_state;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_acc;    // product high half / partial remainder
    logic [WIDTH-1:0]   r_shr;    // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]   r_opnd;   // multiplicand / divisor magnitude
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_divzero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_dtrial;
    logic               w_dok;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_sa = op_is_signed(op) & a[WIDTH-1];
    assign w_sb = op_is_signed(op) & b[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH)) u_abs (
        .i_hi     (a),
        .i_lo     (b),
        .i_neg_hi (w_sa),
        .i_neg_lo (w_sb),
        .i_wide   (1'b0),
        .o_hi     (w_abs_a),
        .o_lo     (w_abs_b)
    );

    // Quotient takes sign_a^sign_b, remainder the dividend sign; the product
    // is negated as a whole when the operand signs differ.
    mdu_sign_fix #(.W(WIDTH)) u_fix (
        .i_hi     (r_acc),
        .i_lo     (r_shr),
        .i_neg_hi (r_is_div ? r_sign_a : (r_sign_a ^ r_sign_b)),
        .i_neg_lo (r_sign_a ^ r_sign_b),
        .i_wide   (~r_is_div),
        .o_hi     (w_fix_hi),
        .o_lo     (w_fix_lo)
    );

    // One iteration step for each algorithm; the FSM picks which to commit.
    // The trial difference can never be >= 2^WIDTH when non-negative because
    // the running remainder is always below the divisor.
    assign w_madd   = {1'b0, r_acc} + (r_shr[0] ? {1'b0, r_opnd} : '0);
    assign w_dshift = {r_acc, r_shr[WIDTH-1]};
    assign w_dtrial = w_dshift - {1'b0, r_opnd};
    assign w_dok    = ~w_dtrial[WIDTH];

    // Control FSM and datapath registers, all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_is_div  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_acc     <= '0;
            r_shr     <= '0;
            r_opnd    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_div <= op_is_div(op);
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        r_shr    <= w_abs_a;
                        r_opnd   <= w_abs_b;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        if (op_is_div(op) && (b == '0)) begin
                            r_state   <= DZ;
                            r_divzero <= 1'b1;
                            r_acc     <= a;   // raw dividend goes to HI
                        end else begin
                            r_state   <= RUN;
                            r_divzero <= 1'b0;
                            r_acc     <= '0;
                        end
                    end else begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                RUN: begin
                    if (r_is_div) begin
                        r_acc <= w_dok ? w_dtrial[WIDTH-1:0] : w_dshift[WIDTH-1:0];
                        r_shr <= {r_shr[WIDTH-2:0], w_dok};
                    end else begin
                        r_acc <= w_madd[WIDTH:1];
                        r_shr <= {w_madd[0], r_shr[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH-1)) r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                DZ: begin
                    r_hi    <= r_acc;
                    r_lo    <= '1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign divzero = r_divzero;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one operation, from integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         output logic [31:0] eh, output logic [31:0] el,
                         output bit edz, output int elat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        edz = 1'b0;
        elat = 34;
        case (o)
            2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = {32'b0, xa} * {32'b0, xb}; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (xb == 0) begin
                    edz = 1'b1; elat = 2; eh = xa; el = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    el = 32'(q); eh = 32'(r);
                end else begin
                    el = xa / xb; eh = xa % xb;
                end
            end
        endcase
    endtask

    // Launch one op, optionally with a move in the start cycle and/or an
    // interfering start+mthi pulse at cycle intf, then check the result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          input int intf, input bit mv);
        logic [31:0] eh, el;
        bit          edz;
        int          elat, cyc, nbusy;
        model(o, xa, xb, eh, el, edz, elat);
        op = o; a = xa; b = xb; start = 1'b1;
        if (mv) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_0000 | $urandom_range(0, 65535); end
        tick;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        cyc = 1; nbusy = 0;
        while (!done && cyc < 60) begin
            if (busy) nbusy++;
            if (cyc == intf) begin
                start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; mthi = 1'b1; wdata = 32'hAAAA;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            tick;
            cyc++;
        end
        start = 1'b0; mthi = 1'b0;
        m_hi = eh; m_lo = el;
        chk($sformatf("latency op%0d", o), 64'(cyc), 64'(elat));
        chk($sformatf("busy_cycles op%0d", o), 64'(nbusy), 64'(elat - 1));
        chk("busy_at_done", busy, 0);
        chk($sformatf("hi op%0d a=%h b=%h", o, xa, xb), hi, m_hi);
        chk($sformatf("lo op%0d a=%h b=%h", o, xa, xb), lo, m_lo);
        chk("divzero", divzero, edz);
        tick;
        chk("done_pulse", done, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0001;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ndone;
        logic [31:0] xa, xb, wv;
        logic [1:0]  o;
        bit          h, l;

        // Reset state
        repeat (3) tick;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_divzero", divzero, 0);
        reset = 1'b1;
        tick;

        // Directed cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(2'b10, 32'h0000_1234, 32'd0, -1, 1'b0);
        run_op(2'b01, 32'd5, 32'd6, 10, 1'b0);
        run_op(2'b01, 32'd11, 32'd13, -1, 1'b1);

        // Both moves in one idle cycle
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1357_9BDF;
        tick;
        mthi = 1'b0; mtlo = 1'b0;
        m_hi = 32'h1357_9BDF; m_lo = 32'h1357_9BDF;
        chk("mt_both_hi", hi, m_hi);
        chk("mt_both_lo", lo, m_lo);

        // Reset in the middle of a MULT
        op = 2'b00; a = 32'h1234_5678; b = 32'hFFFF_0001; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (14) tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        ndone = 0;
        repeat (40) begin
            if (done) ndone++;
            tick;
        end
        chk("abort_no_done", 64'(ndone), 0);
        mtlo = 1'b1; wdata = 32'h55;
        tick;
        mtlo = 1'b0;
        m_lo = 32'h55;
        chk("mtlo_lo", lo, m_lo);
        chk("mtlo_hi", hi, m_hi);

        // Random ops interleaved with idle moves
        for (int i = 0; i < 40; i++) begin
            o  = 2'($urandom);
            xa = pick();
            xb = (o[1] && $urandom_range(0, 5) == 0) ? 32'd0 : pick();
            if ($urandom_range(0, 3) == 0) begin
                h = 1'($urandom); l = 1'($urandom); wv = $urandom;
                mthi = h; mtlo = l; wdata = wv;
                tick;
                mthi = 1'b0; mtlo = 1'b0;
                if (h) m_hi = wv;
                if (l) m_lo = wv;
                chk("rnd_mt_hi", hi, m_hi);
                chk("rnd_mt_lo", lo, m_lo);
            end
            run_op(o, xa, xb, (i % 5 == 0) ? int'($urandom_range(1, 30)) : -1,
                   $urandom_range(0, 5) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
